// File: rtl/mem_stage_if.sv
// Shared widths/op codes for the MEM stage and the byte-serial memory-controller interface.
// The stage drives request/address/data; the controller answers with ready and read data.
package mem_stage_pkg;
  localparam int unsigned REG_LEN      = 32;
  localparam int unsigned ADDR_LEN     = 32;
  localparam int unsigned REG_ADDR_LEN = 5;
  localparam int unsigned ALU_LEN      = 5;

  localparam logic [ALU_LEN-1:0] EXE_NOP = 5'h00;
  localparam logic [ALU_LEN-1:0] EXE_ADD = 5'h01;
  localparam logic [ALU_LEN-1:0] EXE_SUB = 5'h02;
  localparam logic [ALU_LEN-1:0] EXE_OR  = 5'h03;
  localparam logic [ALU_LEN-1:0] EXE_LB  = 5'h08;
  localparam logic [ALU_LEN-1:0] EXE_LH  = 5'h09;
  localparam logic [ALU_LEN-1:0] EXE_LW  = 5'h0A;
  localparam logic [ALU_LEN-1:0] EXE_LBU = 5'h0B;
  localparam logic [ALU_LEN-1:0] EXE_LHU = 5'h0C;
  localparam logic [ALU_LEN-1:0] EXE_SB  = 5'h0D;
  localparam logic [ALU_LEN-1:0] EXE_SH  = 5'h0E;
  localparam logic [ALU_LEN-1:0] EXE_SW  = 5'h0F;
endpackage

interface mem_stage_if;
  logic                                 mc_req;
  logic                                 mc_wr;
  logic [mem_stage_pkg::ADDR_LEN-1:0]   mc_addr;
  logic [7:0]                           mc_wdata;
  logic                                 mc_ready;
  logic [7:0]                           mc_rdata;

  modport master (output mc_req, mc_wr, mc_addr, mc_wdata, input mc_ready, mc_rdata);
  modport slave  (input mc_req, mc_wr, mc_addr, mc_wdata, output mc_ready, mc_rdata);
endinterface

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte-serial loads/stores to the memory controller, load
// assembly with sign/zero extension, and pipeline stall while an access is in flight.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_LEN-1:0]      mem_rd_data,
  input  logic [REG_ADDR_LEN-1:0] mem_rd_addr,
  input  logic                    mem_rd_enable,
  input  logic [ADDR_LEN-1:0]     mem_mem_addr,
  input  logic [ALU_LEN-1:0]      mem_alu_op,
  input  logic [REG_LEN-1:0]      mem_mem_wdata,
  mem_stage_if.master             mc,
  output logic [REG_LEN-1:0]      wb_rd_data,
  output logic [REG_ADDR_LEN-1:0] wb_rd_addr,
  output logic                    wb_rd_enable,
  output logic                    stall_req
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                  r_state;
  logic [1:0]              r_idx;
  logic [ADDR_LEN-1:0]     r_base;
  logic [REG_LEN-1:0]      r_wdata;
  logic [ALU_LEN-1:0]      r_op;
  logic [REG_ADDR_LEN-1:0] r_rdaddr;
  logic                    r_rden;
  logic [7:0]              r_buf [4];
  logic                    r_mc_req;
  logic                    r_mc_wr;
  logic [ADDR_LEN-1:0]     r_mc_addr;
  logic [7:0]              r_mc_wdata;

  logic                    w_in_mem;
  logic                    w_last;
  logic [1:0]              w_idx_inc;
  logic [REG_LEN-1:0]      w_load_data;

  function automatic logic f_is_mem(input logic [ALU_LEN-1:0] op);
    case (op)
      EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU,
      EXE_SB, EXE_SH, EXE_SW:                   return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic f_is_store(input logic [ALU_LEN-1:0] op);
    return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
  endfunction

  // Index of the final byte of the access (size - 1).
  function automatic logic [1:0] f_last_idx(input logic [ALU_LEN-1:0] op);
    case (op)
      EXE_LB, EXE_LBU, EXE_SB: return 2'd0;
      EXE_LH, EXE_LHU, EXE_SH: return 2'd1;
      default:                 return 2'd3;
    endcase
  endfunction

  assign w_in_mem  = f_is_mem(mem_alu_op);
  assign w_last    = (r_idx == f_last_idx(r_op));
  assign w_idx_inc = r_idx + 2'd1;

  // Bus outputs are registered so they hold steady across controller wait states.
  assign mc.mc_req   = r_mc_req;
  assign mc.mc_wr    = r_mc_wr;
  assign mc.mc_addr  = r_mc_addr;
  assign mc.mc_wdata = r_mc_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_op       <= '0;
      r_rdaddr   <= '0;
      r_rden     <= 1'b0;
      r_mc_req   <= 1'b0;
      r_mc_wr    <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_wdata <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_mem) begin
            r_base     <= mem_mem_addr;
            r_wdata    <= mem_mem_wdata;
            r_op       <= mem_alu_op;
            r_rdaddr   <= mem_rd_addr;
            r_rden     <= mem_rd_enable;
            r_idx      <= '0;
            r_mc_req   <= 1'b1;
            r_mc_wr    <= f_is_store(mem_alu_op);
            r_mc_addr  <= mem_mem_addr;
            r_mc_wdata <= mem_mem_wdata[7:0];
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mc.mc_ready) begin
            if (!r_mc_wr) r_buf[r_idx] <= mc.mc_rdata;
            if (w_last) begin
              r_mc_req <= 1'b0;
              r_mc_wr  <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_idx      <= w_idx_inc;
              r_mc_addr  <= r_base + ADDR_LEN'(w_idx_inc);
              r_mc_wdata <= r_wdata[{w_idx_inc, 3'b000} +: 8];
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Little-endian load assembly with extension.
  always_comb begin
    w_load_data = '0;
    case (r_op)
      EXE_LB:  w_load_data = {{24{r_buf[0][7]}}, r_buf[0]};
      EXE_LBU: w_load_data = {24'h000000, r_buf[0]};
      EXE_LH:  w_load_data = {{16{r_buf[1][7]}}, r_buf[1], r_buf[0]};
      EXE_LHU: w_load_data = {16'h0000, r_buf[1], r_buf[0]};
      EXE_LW:  w_load_data = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
      default: w_load_data = '0;
    endcase
  end

  // Writeback/stall: pass-through when idle, captured result in DONE.
  always_comb begin
    wb_rd_data   = mem_rd_data;
    wb_rd_addr   = mem_rd_addr;
    wb_rd_enable = 1'b0;
    stall_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        wb_rd_enable = !rst && !w_in_mem && mem_rd_enable;
        stall_req    = !rst && w_in_mem;
      end
      S_ACCESS: stall_req = !rst;
      S_DONE: begin
        wb_rd_data   = w_load_data;
        wb_rd_addr   = r_rdaddr;
        wb_rd_enable = r_rden && !rst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a byte memory slave plus an independent
// architectural memory model predicts load results, bus beats and stall length.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_enable;
  logic [31:0] mem_mem_addr;
  logic [4:0]  mem_alu_op;
  logic [31:0] mem_mem_wdata;
  logic [31:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_enable;
  logic        stall_req;

  mem_stage_if mc_if();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_mem_addr(mem_mem_addr), .mem_alu_op(mem_alu_op), .mem_mem_wdata(mem_mem_wdata),
    .mc(mc_if.master),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] slave_mem [logic [31:0]];
  logic [7:0] ref_mem   [logic [31:0]];
  int fixed_wait = 0;   // -1: random ready, else fixed wait cycles per byte
  int wcnt = 0;

  logic [4:0] ops [10] = '{EXE_ADD, EXE_OR, EXE_LB, EXE_LH, EXE_LW,
                           EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_slave(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic int op_size(input logic [4:0] op);
    if (op == EXE_LB || op == EXE_LBU || op == EXE_SB) return 1;
    if (op == EXE_LH || op == EXE_LHU || op == EXE_SH) return 2;
    if (op == EXE_LW || op == EXE_SW) return 4;
    return 0;
  endfunction

  function automatic bit op_store(input logic [4:0] op);
    return op == EXE_SB || op == EXE_SH || op == EXE_SW;
  endfunction

  // Architectural load value: little-endian integer, then two's-complement reinterpretation.
  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] a);
    longint v = 0;
    int n = op_size(op);
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(rd_ref(a + 32'(i)));
    if ((op == EXE_LB || op == EXE_LH) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    slave_mem[a] = d;
    ref_mem[a]   = d;
  endtask

  // Controller model: ready/rdata updated just after each rising edge.
  initial begin
    mc_if.mc_ready = 1'b0;
    mc_if.mc_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (fixed_wait < 0) mc_if.mc_ready = ($urandom_range(0, 1) == 1);
      else                mc_if.mc_ready = (wcnt >= fixed_wait);
      mc_if.mc_rdata = rd_slave(mc_if.mc_addr);
    end
  end

  // A byte is accepted when req and ready are both high ahead of the next edge.
  always @(negedge clk) begin
    if (rst || !mc_if.mc_req) wcnt = 0;
    else if (mc_if.mc_ready) begin
      if (mc_if.mc_wr) slave_mem[mc_if.mc_addr] = mc_if.mc_wdata;
      wcnt = 0;
    end else wcnt++;
  end

  // Issue one instruction while the stage is idle; returns just after the edge leaving DONE.
  task automatic run_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rda, input logic rde, input logic [31:0] rdd);
    int n, stalls, waits, beats;
    bit done, held;
    logic [31:0] h_addr, exp;
    logic [7:0]  h_wd;
    mem_alu_op = op; mem_mem_addr = addr; mem_mem_wdata = wdata;
    mem_rd_addr = rda; mem_rd_enable = rde; mem_rd_data = rdd;
    #1;
    if (op_size(op) == 0) begin
      check("pt_data", wb_rd_data, rdd);
      check("pt_addr", 32'(wb_rd_addr), 32'(rda));
      check("pt_en", 32'(wb_rd_enable), 32'(rde));
      check("pt_stall", 32'(stall_req), 0);
      check("pt_req", 32'(mc_if.mc_req), 0);
      @(posedge clk); #1;
      return;
    end
    check("idle_stall", 32'(stall_req), 1);
    check("idle_en", 32'(wb_rd_enable), 0);
    check("idle_req", 32'(mc_if.mc_req), 0);
    n = op_size(op); stalls = 1; waits = 0; beats = 0; done = 0; held = 0;
    h_addr = '0; h_wd = '0;
    @(posedge clk); #2;
    mem_alu_op = ops[$urandom_range(0, 9)]; mem_mem_addr = $urandom; mem_mem_wdata = $urandom;
    mem_rd_addr = 5'($urandom); mem_rd_enable = 1'($urandom); mem_rd_data = $urandom;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!stall_req) done = 1;
      else begin
        stalls++;
        check("acc_req", 32'(mc_if.mc_req), 1);
        check("acc_en", 32'(wb_rd_enable), 0);
        if (held) begin
          check("hold_addr", mc_if.mc_addr, h_addr);
          check("hold_wdata", 32'(mc_if.mc_wdata), 32'(h_wd));
        end
        if (mc_if.mc_ready) begin
          if (beats < n) begin
            check("beat_addr", mc_if.mc_addr, addr + 32'(beats));
            check("beat_wr", 32'(mc_if.mc_wr), 32'(op_store(op)));
            if (op_store(op)) check("beat_wdata", 32'(mc_if.mc_wdata), 32'((wdata >> (8 * beats)) & 32'hFF));
          end
          beats++; held = 0;
        end else begin
          waits++; held = 1; h_addr = mc_if.mc_addr; h_wd = mc_if.mc_wdata;
        end
      end
    end
    if (!done) check("done_timeout", 0, 1);
    else begin
      exp = op_store(op) ? 32'h0 : ref_load(op, addr);
      check("beats", 32'(beats), 32'(n));
      check("stall_cycles", 32'(stalls), 32'(1 + n + waits));
      check("done_req", 32'(mc_if.mc_req), 0);
      check("done_data", wb_rd_data, exp);
      check("done_addr", 32'(wb_rd_addr), 32'(rda));
      check("done_en", 32'(wb_rd_enable), 32'(rde));
    end
    if (op_store(op)) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_alu_op = EXE_LW; mem_mem_addr = 32'h40; mem_mem_wdata = '0;
    mem_rd_addr = 5'd3; mem_rd_enable = 1'b1; mem_rd_data = 32'hDEAD;
    #12;
    check("rst_req", 32'(mc_if.mc_req), 0);
    check("rst_wr", 32'(mc_if.mc_wr), 0);
    check("rst_addr", mc_if.mc_addr, 0);
    check("rst_wdata", 32'(mc_if.mc_wdata), 0);
    check("rst_stall", 32'(stall_req), 0);
    check("rst_en", 32'(wb_rd_enable), 0);
    check("rst_pt_data", wb_rd_data, 32'hDEAD);
    mem_alu_op = EXE_ADD;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Pass-through and the simple loads
    run_op(EXE_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    run_op(EXE_LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);
    check("lw_value", ref_load(EXE_LW, 32'h100), 32'h12345678);
    poke(32'h200, 8'h80);
    run_op(EXE_LB, 32'h200, 32'h0, 5'd8, 1'b1, 32'h0);
    run_op(EXE_LBU, 32'h200, 32'h0, 5'd9, 1'b1, 32'h0);
    poke(32'h210, 8'h34); poke(32'h211, 8'hF2);
    run_op(EXE_LH, 32'h210, 32'h0, 5'd10, 1'b1, 32'h0);

    // Store halfword across the address wrap with wait states
    fixed_wait = 2;
    run_op(EXE_SH, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd0, 1'b0, 32'h0);
    check("sh_mem0", 32'(rd_slave(32'hFFFFFFFF)), 32'hDD);
    check("sh_mem1", 32'(rd_slave(32'h00000000)), 32'hCC);
    fixed_wait = 0;

    // Reset in the middle of a word store after two bytes are accepted
    mem_alu_op = EXE_SW; mem_mem_addr = 32'h300; mem_mem_wdata = 32'hCAFEBABE;
    mem_rd_addr = 5'd0; mem_rd_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mc_if.mc_req), 0);
    check("mid_rst_stall", 32'(stall_req), 0);
    mem_alu_op = EXE_ADD;
    @(negedge clk); rst = 1'b0;
    ref_mem[32'h300] = 8'hBE; ref_mem[32'h301] = 8'hBA;
    @(posedge clk); #1;
    run_op(EXE_LW, 32'h300, 32'h0, 5'd11, 1'b1, 32'h0);

    // Back-to-back load then ALU op
    run_op(EXE_LW, 32'h100, 32'h0, 5'd12, 1'b1, 32'h0);
    run_op(EXE_ADD, 32'h0, 32'h0, 5'd13, 1'b1, 32'h5555AAAA);

    // Random mix
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0:       a = 32'h1000 + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: a = 32'h100 + 32'($urandom_range(0, 7));
      endcase
      fixed_wait = ($urandom_range(0, 1) == 1) ? -1 : 0;
      run_op(ops[$urandom_range(0, 9)], a, $urandom, 5'($urandom), 1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM register outputs and performs loads and stores through a byte-serial request/ready port to the memory controller.
- Assembles load bytes (little-endian), applies sign or zero extension, and drives writeback data.
- Raises a stall request that freezes IF through EX/MEM while an access is in flight.

Parameters:
None. All widths come from config.v macros: `RegLen = 32, `AddrLen = 32, `RegAddrLen = 5, `ALU_Len. Op encodings are the config.v `EXE_LB/LH/LW/LBU/LHU/SB/SH/SW macros.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_rd_data  in  `RegLen  ALU result from EX/MEM
mem_rd_addr  in  `RegAddrLen  destination register
mem_rd_enable  in  1  destination write enable
mem_mem_addr  in  `AddrLen  effective load/store address
mem_alu_op  in  `ALU_Len  operation code
mem_mem_wdata  in  `RegLen  store data (rs2)
mc_req  out  1  byte request valid
mc_wr  out  1  1 = write, 0 = read
mc_addr  out  `AddrLen  byte address
mc_wdata  out  8  write byte
mc_ready  in  1  current byte accepted; on a read, mc_rdata is valid in the same cycle
mc_rdata  in  8  read byte
wb_rd_data  out  `RegLen  to MEM/WB
wb_rd_addr  out  `RegAddrLen  to MEM/WB
wb_rd_enable  out  1  to MEM/WB
stall_req  out  1  to pipeline control; holds EX/MEM and upstream stages, inserts a bubble into MEM/WB

Behaviour:
- Reset (async, rst=1):
  - State IDLE; idx, base_q, wdata_q, op_q, rdaddr_q, rden_q, and the byte buffer are all 0.
  - mc_req=0, mc_wr=0, mc_addr=0, mc_wdata=0, stall_req=0, wb_rd_enable=0.
  - wb_rd_data and wb_rd_addr follow the IDLE pass-through rule.
- Access size: B=1, H=2, W=4 bytes. Byte i is at base + i, with the address wrapping mod 2^32. There is no alignment requirement.
- IDLE:
  - Non-memory op: combinational pass-through; wb_* = mem_rd_*; stall_req=0.
  - Memory op: stall_req=1 (combinational, same cycle) and wb_rd_enable=0.
  - On the clock edge: capture mem_mem_addr, mem_mem_wdata, mem_alu_op, mem_rd_addr, mem_rd_enable; set idx=0; go to ACCESS.
- ACCESS:
  - Outputs are Moore, from registers: mc_req=1, mc_addr=base_q+idx, mc_wr=1 for SB/SH/SW, mc_wdata=wdata_q[8*idx+7:8*idx].
  - stall_req=1, wb_rd_enable=0.
  - mc_ready=0: hold all outputs; the wait is unbounded.
  - mc_ready=1 on a read: buf[idx] <= mc_rdata.
  - mc_ready=1 with idx < size-1: idx++.
  - mc_ready=1 with idx == size-1: go to DONE; mc_req drops next cycle.
- DONE (exactly 1 cycle):
  - mc_req=0, stall_req=0.
  - wb_rd_addr=rdaddr_q, wb_rd_enable=rden_q.
  - wb_rd_data by op:
    - LB: sign-extend buf0
    - LBU: zero-extend buf0
    - LH: sign-extend {buf1,buf0}
    - LHU: zero-extend {buf1,buf0}
    - LW: {buf3,buf2,buf1,buf0}
    - Stores: 0, with wb_rd_enable = rden_q (0 for stores).
  - Next state is IDLE unconditionally. The following instruction enters on this edge because stall is low.
- Latency: with mc_ready tied high, a W access occupies IDLE + 4×ACCESS + DONE = 6 cycles, with stall_req high for 5. B occupies 3 cycles, H occupies 4.
- Inputs may change after capture; results depend only on the captured copies.
- Reset mid-access aborts immediately to IDLE. Bytes of a store already accepted stay written (partial store is architecturally allowed only across reset).
- mc_req never asserts outside ACCESS. mc_addr and mc_wdata are stable while mc_req=1 and mc_ready=0.

Test Plan:
1. ADD pass-through: op=ADD, rd_data=0x1234, rd_addr=5, rd_enable=1 -> same cycle wb = 0x1234 / 5 / 1; stall_req=0; mc_req never asserted.
2. LW at 0x100, mc_ready always 1, mc_rdata = 0x78, 0x56, 0x34, 0x12 -> mc_addr sequence 0x100..0x103 with mc_wr=0; stall_req high 5 cycles; DONE wb_rd_data = 0x12345678.
3. LB at 0x200 returning 0x80 -> wb_rd_data = 0xFFFFFF80; LBU with the same byte -> 0x00000080; LH with bytes 0x34, 0xF2 -> 0xFFFFF234.
4. SH at 0xFFFFFFFF, wdata = 0xAABBCCDD, mc_ready low for 2 cycles on each byte -> byte 0xDD @0xFFFFFFFF, then 0xCC @0x00000000; outputs held while waiting; wb_rd_enable=0 throughout.
5. Reset during ACCESS of an SW after byte 1 is accepted -> mc_req=0 and stall_req=0 asynchronously; state IDLE; next LW completes normally.
6. Back-to-back LW then ADD -> ADD result appears in the cycle after DONE with no lost or duplicated writeback.
